// File: rtl/eregisterfile_sweep.sv
// Parametrised dual-read register bank with a one-entry-per-cycle clear sweep, write bypass and
// dropped-write pulse. Define EREGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module eregisterfile_sweep #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [DATA_W-1:0] wd,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              busy,
    output logic              wr_drop
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
    logic              wr_drop_q, wr_drop_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic idle;
    logic wr_hit;
    logic wr_commit;
    logic bypass_en;

    assign idle = (state_q == StIdle);

    // A write only "exists" if it targets real storage; writes to the hardwired
    // zero entry are neither committed nor reported as dropped.
`ifdef EREGFILE_ZERO_REG_EN
    assign wr_hit = we && (wa != '0);
`else
    assign wr_hit = we;
`endif

    assign wr_commit = idle && wr_hit && !clr;
    assign bypass_en = we && !clr;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        wr_drop_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d   = StClear;
                    clr_idx_d = '0;
                    wr_drop_d = wr_hit;
                end
            end
            StClear: begin
                clr_idx_d = clr_idx_q + ADDR_W'(1);
                wr_drop_d = wr_hit;
                if (clr_idx_q == LastIdx) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d   = StClear;
                clr_idx_d = '0;
            end
        endcase
        // Reset wins over everything and silently discards any write.
        if (rst) begin
            state_d   = StClear;
            clr_idx_d = '0;
            wr_drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_idx_q <= clr_idx_d;
        wr_drop_q <= wr_drop_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
        end else if (state_q == StClear) begin
            mem_q[clr_idx_q] <= '0;
        end else if (wr_commit) begin
            mem_q[wa] <= wd;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              byp,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata,
        input logic              sweeping
    );
        logic [DATA_W-1:0] val;
        val = stored;
        if (byp && (addr == waddr)) begin
            val = wdata;
        end
`ifdef EREGFILE_ZERO_REG_EN
        if (addr == '0) begin
            val = '0;
        end
`endif
        if (sweeping) begin
            val = '0;
        end
        return val;
    endfunction

    assign busy    = (state_q == StClear);
    assign wr_drop = wr_drop_q;
    assign rd1     = read_port(ra1, mem_q[ra1], bypass_en, wa, wd, busy);
    assign rd2     = read_port(ra2, mem_q[ra2], bypass_en, wa, wd, busy);

endmodule

// File: doc/eregisterfile_sweep.md
Name: eregisterfile_sweep

Overview:
- Parametrised successor to the team's 8x8 dual-read register file.
- Generalised data width and depth.
- Adds a hardware clear sequencer that zeroes every entry one per cycle after reset or on request, with a busy flag.
- Adds write-to-read bypass and a dropped-write indicator.
- Sits in the datapath as the general-purpose register bank feeding the ALU operand buses.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset; starts a clear sweep.
- clr  input  1  synchronous clear request; starts a clear sweep when idle.
- we  input  1  write enable.
- wa  input  ADDR_W  write address.
- wd  input  DATA_W  write data.
- ra1  input  ADDR_W  read address, port 1.
- ra2  input  ADDR_W  read address, port 2.
- rd1  output  DATA_W  read data, port 1 (combinational).
- rd2  output  DATA_W  read data, port 2 (combinational).
- busy  output  1  high while the clear sweep is in progress.
- wr_drop  output  1  one-cycle pulse: a write was discarded.

Behaviour:
- The clock is clk. Reset is rst: synchronous, active-high. No asynchronous reset anywhere.
- State machine has two states:
  - IDLE: normal operation.
  - CLEAR: sweep in progress.
- Sweep counter clr_idx is ADDR_W bits.
- Reset:
  - At any edge with rst=1: state<=CLEAR, clr_idx<=0, wr_drop<=0, and registers[0]<=0.
  - rst overrides clr and we.
  - rst asserted mid-sweep restarts the sweep from index 0.
- CLEAR state (rst=0), on each edge:
  - registers[clr_idx] <= 0; clr_idx <= clr_idx+1.
  - At the edge where clr_idx==DEPTH-1: state<=IDLE and clr_idx wraps to 0.
  - Sweep therefore takes exactly DEPTH edges after rst falls (or after clr is accepted).
- busy = (state==CLEAR). It is a registered-state decode, so busy is high immediately after the reset edge. busy is low in the first cycle after the final clear edge.
- clr:
  - Sampled only in IDLE. clr=1 at an IDLE edge sets state<=CLEAR, clr_idx<=0. No entry is cleared on that edge.
  - clr is ignored during CLEAR; a sweep is never extended or restarted by clr.
  - clr held high continuously causes back-to-back sweeps, with one IDLE cycle between them.
- Write:
  - In IDLE with we=1 and clr=0: registers[wa] <= wd at the edge.
  - If we=1 coincides with clr=1 in IDLE, the write is discarded.
  - If we=1 during CLEAR, the write is discarded.
  - A discarded write sets wr_drop=1 for the following cycle; otherwise wr_drop=0.
  - A write with rst=1 is discarded silently (wr_drop=0).
- Read:
  - rdN = 0 whenever busy=1.
  - Otherwise, if we=1 and clr=0 and raN==wa, then rdN = wd (write-first bypass; new data visible in the same cycle).
  - Otherwise rdN = registers[raN].
  - Both ports are independent. Both may address the same entry and may both bypass.
- Reset values:
  - busy=1 after the reset edge.
  - wr_drop=0.
  - rd1/rd2=0 while busy.
  - Register contents are all 0 once busy falls.
- Power-up before the first rst: contents undefined. The bench must apply rst first.

Optional Feature:
- Macro: EREGFILE_ZERO_REG_EN.
- When defined: entry 0 is hardwired to zero.
  - Reads of address 0 return 0, including through the bypass path.
  - Writes to wa==0 never update storage and never set wr_drop.
  - The sweep still runs over all DEPTH entries, so timing is unchanged.
- When undefined: entry 0 is an ordinary register.

Test Plan:
- DATA_W=8, ADDR_W=3. rst high for 2 cycles, then low -> busy high for exactly 8 cycles after rst falls, rd1/rd2=0 throughout; afterwards every address reads 0x00 and wr_drop=0.
- Idle; write 0xA5 to addr 3 with ra1=3 -> rd1=0xA5 combinationally in the same cycle (bypass). Next cycle, with we=0, rd1=0xA5 from storage.
- Fill all 8 entries with 0x10..0x17, then pulse clr for 1 cycle -> busy high for 8 cycles; a write of 0xFF to addr 2 mid-sweep -> wr_drop=1 for one cycle; after busy falls, all entries read 0x00.
- Assert rst at sweep index 5 -> sweep restarts; busy stays high for 8 further cycles after rst falls.
- Same-cycle we=1 and clr=1 in IDLE -> write discarded, wr_drop=1, sweep starts, address unchanged (0 after the sweep).
- With EREGFILE_ZERO_REG_EN defined: write 0x3C to addr 0 with ra2=0 -> rd2=0x00 in the same cycle and after, wr_drop=0. Without the macro -> rd2=0x3C.
